noise_injector: RTL

Parametrised, stream-based successor to the single-channel 8-bit LFSR noise adder. Takes a signed sample stream with valid/ready handshake and adds pseudo-random noise from a configurable Fibonacci LFSR. Noise amplitude is programmable, the sum is saturated, and saturation events are counted. It sits between a clean signal source and downstream DSP/test logic, so its output is a bit-exact, reproducible noisy stream for channel-impairment testing.

---
 rtl/noise_injector.sv | 127 ++++++++++++
 1 files changed

// File: rtl/noise_injector.sv
// Stream noise injector: adds a window of a Fibonacci LFSR, scaled by an arithmetic
// shift, to each accepted signed sample, saturating the sum and counting clips.
module noise_injector #(
    parameter int                DATA_W    = 8,
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] TAPS      = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
    parameter int                NOISE_W   = 4,
    parameter int                NOISE_LSB = 8,
    localparam int               SHIFT_W   = (NOISE_W > 1) ? $clog2(NOISE_W) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic signed [DATA_W-1:0] s_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic signed [DATA_W-1:0] m_data,
    output logic                     m_sat,
    input  logic                     cfg_en,
    input  logic [SHIFT_W-1:0]       cfg_shift,
    input  logic                     seed_load,
    input  logic [LFSR_W-1:0]        seed_value,
    input  logic                     cnt_clr,
    output logic [15:0]              sat_count
);

    localparam logic [NOISE_W-1:0]       NOISE_BIAS = NOISE_W'(1) << (NOISE_W - 1);
    localparam logic signed [DATA_W:0]   SUM_MAX    = {2'b00, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W:0]   SUM_MIN    = {2'b11, {(DATA_W-1){1'b0}}};

    logic [LFSR_W-1:0]        lfsr_q, lfsr_d;
    logic                     m_valid_q, m_valid_d;
    logic signed [DATA_W-1:0] m_data_q, m_data_d;
    logic                     m_sat_q, m_sat_d;
    logic [15:0]              sat_count_q, sat_count_d;

    logic                     acc;
    logic                     fb;
    logic [NOISE_W-1:0]       raw;
    logic signed [NOISE_W-1:0] noise;
    logic signed [NOISE_W-1:0] noise_sh;
    logic signed [DATA_W:0]   sum;
    logic signed [DATA_W-1:0] result;
    logic                     sat;

    // One-entry output register: a new sample can enter whenever the current one leaves.
    assign s_ready = !m_valid_q || m_ready;
    assign acc     = s_valid && s_ready;

    always_comb begin
        raw      = lfsr_q[NOISE_LSB +: NOISE_W];
        // Subtracting the mid-point is the same as flipping the window MSB.
        noise    = $signed(raw ^ NOISE_BIAS);
        noise_sh = noise >>> cfg_shift;
        sum      = (DATA_W+1)'(s_data) + (DATA_W+1)'(noise_sh);
        result   = s_data;
        sat      = 1'b0;
        if (cfg_en) begin
            if (sum > SUM_MAX) begin
                result = SUM_MAX[DATA_W-1:0];
                sat    = 1'b1;
            end else if (sum < SUM_MIN) begin
                result = SUM_MIN[DATA_W-1:0];
                sat    = 1'b1;
            end else begin
                result = sum[DATA_W-1:0];
            end
        end
    end

    always_comb begin
        fb     = ^(lfsr_q & TAPS);
        lfsr_d = lfsr_q;
        // A reload wins over an advance; the sample accepted this cycle already used lfsr_q.
        if (seed_load) begin
            lfsr_d = (seed_value == '0) ? SEED : seed_value;
        end else if (acc) begin
            lfsr_d = {lfsr_q[LFSR_W-2:0], fb};
        end
    end

    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_sat_d   = m_sat_q;
        if (acc) begin
            m_valid_d = 1'b1;
            m_data_d  = result;
            m_sat_d   = sat;
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    always_comb begin
        sat_count_d = sat_count_q;
        if (cnt_clr) begin
            sat_count_d = '0;
        end else if (acc && sat && (sat_count_q != 16'hFFFF)) begin
            sat_count_d = sat_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q      <= SEED;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_sat_q     <= 1'b0;
            sat_count_q <= '0;
        end else begin
            lfsr_q      <= lfsr_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_sat_q     <= m_sat_d;
            sat_count_q <= sat_count_d;
        end
    end

    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_sat     = m_sat_q;
    assign sat_count = sat_count_q;

endmodule
